mem_access_sequencer: RTL
=========================

Name: mem_access_sequencer

Overview:
- Sits between the control unit and the 128x32 byte-addressed RAM: accepts one memory request, drives RAM Enable/OpCode/Address/DataIn, waits for MFC and returns read data plus a one-cycle Done.
- Splits doubleword loads/stores and SWAP into two back-to-back single-word RAM accesses.
- Rejects illegal or misaligned requests without touching memory.

Parameters:
ADDR_W, 7, RAM byte-address width; all address arithmetic is modulo 2^ADDR_W.
TIMEOUT_CYCLES, 16, max WAIT cycles before timeout error (used only with MEM_TIMEOUT_EN).

Ports:
Clk  in  1  system clock, rising edge.
Reset_n  in  1  asynchronous active-low reset.
Req  in  1  request strobe from control unit, sampled only in IDLE.
Op  in  6  request opcode (encoding below).
Addr  in  ADDR_W  byte address.
WrData0  in  32  write data (word 0, or only word).
WrData1  in  32  second write word for doubleword store.
Busy  out  1  high from the cycle after acceptance until Done.
Done  out  1  one-cycle completion pulse.
Err  out  1  valid with Done; 1 = request failed.
ErrCode  out  2  01 illegal op, 10 misaligned, 11 timeout, 00 none.
RdData0  out  32  first/only read word (SWAP: old memory word).
RdData1  out  32  second read word (doubleword load).
Mem_Enable  out  1  RAM enable.
Mem_OpCode  out  6  RAM opcode.
Mem_Address  out  ADDR_W  RAM address.
Mem_DataIn  out  32  RAM write data.
Mem_DataOut  in  32  RAM read data.
Mem_MFC  in  1  RAM memory-function-complete.

Behaviour:
- Reset (async, Reset_n=0): state IDLE; all outputs 0; RdData0/1 = 0; Mem_Enable drops immediately, even mid-access.
- Op encoding: writes 000000 word, 000001 ubyte, 000010 uhalf, 001001 sbyte, 001010 shalf; reads 000100 word, 000101 byte, 000110 half; 000011 doubleword write; 000111 doubleword read; 001111 SWAP. Any other value is illegal.
- Alignment: word/SWAP need Addr[1:0]=0; halfword needs Addr[0]=0; doubleword needs Addr[2:0]=0; byte has no constraint.
- States: IDLE, ISSUE, WAIT, GAP, DONE, ERR.
- IDLE: on Req=1, capture Op, Addr and WrData0/1 into registers and clear phase.
  - Illegal or misaligned request -> ERR; otherwise -> ISSUE.
  - Illegal op takes priority over misalignment.
- ISSUE (1 cycle): Mem_Enable=1; drive Mem_OpCode, Mem_Address and Mem_DataIn for the current phase; -> WAIT.
- WAIT: hold Mem_Enable and RAM outputs stable. On Mem_MFC=1:
  - if the phase is a read, capture Mem_DataOut into RdData0 (phase 0) or RdData1 (phase 1);
  - if a second phase remains -> GAP, else -> DONE.
- GAP (1 cycle): Mem_Enable=0 so the RAM sees a fresh enable edge; phase=1; -> ISSUE.
- DONE (1 cycle): Done=1, Err=0, ErrCode=00, Mem_Enable=0; -> IDLE.
- ERR (1 cycle): Done=1, Err=1, ErrCode set; RAM is never enabled; RdData unchanged; -> IDLE.
- Phase mapping:
  - single access: phase 0 uses Op and Addr as given.
  - doubleword write: phase 0 = 000000 at Addr with WrData0; phase 1 = 000000 at Addr+4 with WrData1.
  - doubleword read: phase 0 = 000100 at Addr into RdData0; phase 1 = 000100 at Addr+4 into RdData1.
  - SWAP: phase 0 = 000100 at Addr into RdData0; phase 1 = 000000 at Addr with WrData0.
- Busy=1 in ISSUE, WAIT, GAP and DONE; 0 in IDLE and ERR.
- Latency, with MFC high in the first WAIT cycle and Req accepted at edge 0: single access Done at edge 3; two-phase access Done at edge 6; error Done at edge 1.
- Req while not in IDLE (including the DONE cycle) is ignored and not queued.
- Mem_MFC outside WAIT is ignored.
- Mem_DataIn is 0 on read phases.

Optional Feature:
MEM_TIMEOUT_EN:
- Defined: a counter clears on entry to WAIT and counts WAIT cycles. If TIMEOUT_CYCLES elapse without Mem_MFC, drop Mem_Enable and go to ERR with ErrCode=11; the remaining phase is abandoned.
- Not defined: WAIT lasts indefinitely until Mem_MFC; ErrCode 11 is never produced.

Test Plan:
- Word write Op=000000, Addr=8, WrData0=DEADBEEF, MFC at the first WAIT cycle -> Mem_Enable high 2 cycles, Mem_DataIn=DEADBEEF, Done at edge 3, Err=0.
- Doubleword read Op=000111, Addr=16, memory holds 11223344 at 16 and 55667788 at 20 -> one GAP cycle with Mem_Enable=0, Mem_Address 16 then 20, RdData0=11223344, RdData1=55667788, Done at edge 6.
- SWAP Op=001111, Addr=4, mem[4]=AAAA5555, WrData0=12345678 -> RdData0=AAAA5555, then a word write of 12345678 at 4; a follow-up word read returns 12345678.
- Op=000100, Addr=6 -> Done+Err at edge 1, ErrCode=10, Mem_Enable never asserted; Op=111111 -> ErrCode=01.
- Reset_n pulled low during WAIT of a doubleword write -> Mem_Enable=0 and Busy=0 immediately; after release, a new Req is accepted normally.
- MEM_TIMEOUT_EN defined, TIMEOUT_CYCLES=4, MFC held low -> Err=1, ErrCode=11 after 4 WAIT cycles; without the macro, Busy stays high until MFC.

Source files
------------

// File: rtl/mem_access_sequencer.sv
// mem_access_sequencer: one-request memory sequencer between the control unit and a 128x32 byte-addressed RAM.
// Doubleword loads/stores and SWAP are split into two single-word RAM accesses with a
// one-cycle enable-low GAP between them. Illegal or misaligned requests go straight to ERR.
// Optional feature macro: MEM_TIMEOUT_EN (WAIT gives up after TIMEOUT_CYCLES, ErrCode 11).
// Ports:
//   Clk, Reset_n            clock (rising edge), asynchronous active-low reset
//   Req, Op, Addr           request strobe, opcode, byte address (sampled in IDLE)
//   WrData0, WrData1        write words (WrData1 only for doubleword store)
//   Busy, Done, Err, ErrCode  status; Done is a one-cycle pulse, Err/ErrCode valid with it
//   RdData0, RdData1        read words (SWAP returns the old word on RdData0)
//   Mem_Enable, Mem_OpCode, Mem_Address, Mem_DataIn  RAM request side
//   Mem_DataOut, Mem_MFC    RAM read data and completion
module mem_access_sequencer #(
    parameter int ADDR_W         = 7,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Req,
    input  logic [5:0]        Op,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [31:0]       WrData0,
    input  logic [31:0]       WrData1,
    output logic              Busy,
    output logic              Done,
    output logic              Err,
    output logic [1:0]        ErrCode,
    output logic [31:0]       RdData0,
    output logic [31:0]       RdData1,
    output logic              Mem_Enable,
    output logic [5:0]        Mem_OpCode,
    output logic [ADDR_W-1:0] Mem_Address,
    output logic [31:0]       Mem_DataIn,
    input  logic [31:0]       Mem_DataOut,
    input  logic              Mem_MFC
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, GAP, DONE, ERR} state_t;

    state_t            state, next;
    logic [5:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wd0_q, wd1_q;
    logic              phase;
    logic [1:0]        err_q;
    logic              legal, misaligned;
    logic              dw, swap, two;
    logic [5:0]        cur_op;
    logic              cur_rd;
    logic [ADDR_W-1:0] cur_addr;
    logic [31:0]       cur_din;
    logic              tmo;

    // Classification of the incoming request, used only when it is accepted in IDLE.
    always_comb begin
        legal      = Op inside {6'b000000, 6'b000001, 6'b000010, 6'b001001, 6'b001010,
                                6'b000100, 6'b000101, 6'b000110, 6'b000011, 6'b000111, 6'b001111};
        misaligned = ((Op inside {6'b000000, 6'b000100, 6'b001111}) && Addr[1:0] != 2'b00) ||
                     ((Op inside {6'b000010, 6'b001010, 6'b000110}) && Addr[0]) ||
                     ((Op inside {6'b000011, 6'b000111}) && Addr[2:0] != 3'b000);
    end

    // Per-phase RAM command. After mapping, bit 2 of the opcode marks a read.
    always_comb begin
        dw       = op_q == 6'b000011 || op_q == 6'b000111;
        swap     = op_q == 6'b001111;
        two      = dw || swap;
        cur_op   = op_q == 6'b000011 ? 6'b000000 :
                   op_q == 6'b000111 ? 6'b000100 :
                   swap              ? (phase ? 6'b000000 : 6'b000100) : op_q;
        cur_rd   = cur_op[2];
        cur_addr = (dw && phase) ? addr_q + ADDR_W'(4) : addr_q;
        cur_din  = cur_rd ? 32'd0 : ((dw && phase) ? wd1_q : wd0_q);
    end

`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt;

    assign tmo = state == WAIT && !Mem_MFC && cnt == CW'(TIMEOUT_CYCLES - 1);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            cnt <= '0;
        else if (state == ISSUE)
            cnt <= '0;
        else if (state == WAIT)
            cnt <= cnt + 1'b1;
    end
`else
    logic unused_tmo;
    assign tmo        = 1'b0;
    assign unused_tmo = TIMEOUT_CYCLES[0];
`endif

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            state <= IDLE;
        else
            state <= next;
    end

    always_comb begin
        next = state;
        case (state)
            IDLE:    next = Req ? ((!legal || misaligned) ? ERR : ISSUE) : IDLE;
            ISSUE:   next = WAIT;
            WAIT:    next = Mem_MFC ? ((two && !phase) ? GAP : DONE) : (tmo ? ERR : WAIT);
            GAP:     next = ISSUE;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            op_q    <= '0;
            addr_q  <= '0;
            wd0_q   <= '0;
            wd1_q   <= '0;
            phase   <= 1'b0;
            err_q   <= 2'b00;
            RdData0 <= '0;
            RdData1 <= '0;
        end else begin
            if (state == IDLE && Req) begin
                op_q   <= Op;
                addr_q <= Addr;
                wd0_q  <= WrData0;
                wd1_q  <= WrData1;
                phase  <= 1'b0;
                err_q  <= !legal ? 2'b01 : (misaligned ? 2'b10 : 2'b00);
            end
            if (state == GAP)
                phase <= 1'b1;
            if (state == WAIT && Mem_MFC && cur_rd) begin
                if (phase)
                    RdData1 <= Mem_DataOut;
                else
                    RdData0 <= Mem_DataOut;
            end
            if (tmo)
                err_q <= 2'b11;
        end
    end

    // RAM command is only driven while enabled so the bus idles at zero.
    always_comb begin
        Mem_Enable  = state == ISSUE || state == WAIT;
        Mem_OpCode  = Mem_Enable ? cur_op : 6'd0;
        Mem_Address = Mem_Enable ? cur_addr : '0;
        Mem_DataIn  = Mem_Enable ? cur_din : 32'd0;
        Busy        = state == ISSUE || state == WAIT || state == GAP || state == DONE;
        Done        = state == DONE || state == ERR;
        Err         = state == ERR;
        ErrCode     = state == ERR ? err_q : 2'b00;
    end
endmodule
